wave_capture: RTL

- Acquisition stage directly upstream of the LCD display controller.
- Decimates 8-bit ADC samples and waits for a level/slope trigger, keeping a programmable pre-trigger history.
- Stores one 480-sample screen into a ping-pong buffer.
- Serves the display's per-pixel sample reads (get_show_data_cnt -> get_show_data) from the bank not being written.
- Banks swap only at a display frame boundary, so the trace never tears mid-frame.

---
 rtl/osc_pkg.sv | 27 ++
 rtl/capture_ram.sv | 33 +++
 rtl/wave_capture.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/osc_pkg.sv
// Shared types and constants for the waveform acquisition path.
// Capture FSM encoding, slope encodings and the timebase clamp helper.
package osc_pkg;

    localparam int SAMPLE_W = 8;
    localparam int SHOW_W   = 480;
    localparam int ADDR_W   = 9;
    localparam int TB_MAX   = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        ARMED     = 3'd2,
        POST_FILL = 3'd3,
        DONE      = 3'd4
    } cap_state_t;

    typedef enum logic {
        SLOPE_RISE = 1'b0,
        SLOPE_FALL = 1'b1
    } slope_t;

    function automatic logic [3:0] clamp_tb(input logic [3:0] tb);
        return (tb > 4'(TB_MAX)) ? 4'(TB_MAX) : tb;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Two-bank sample store: simple dual-port RAM, synchronous write, registered read.
// The bank select is the address MSB, so the capture and display banks never collide.
module capture_ram #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register reset only; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wave_capture.sv
// Decimating level/slope-triggered capture into a ping-pong screen buffer for the LCD.
// Optional macro AUTO_TRIG_EN: force a trigger after AUTO_TIMEOUT armed ticks.
module wave_capture #(
    parameter int SHOW_W       = osc_pkg::SHOW_W,
    parameter int PRE_DEPTH    = 240,
    parameter int ADDR_W       = osc_pkg::ADDR_W,
    parameter int AUTO_TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        adc_data,
    input  logic              adc_valid,
    input  logic              run,
    input  logic [7:0]        trig_level,
    input  logic              trig_slope,
    input  logic [3:0]        timebase,
    input  logic              frame_done,
    input  logic [ADDR_W-1:0] get_show_data_cnt,
    output logic [7:0]        get_show_data,
    output logic              capture_busy,
    output logic              triggered,
    output logic              disp_bank
);
    import osc_pkg::*;

    localparam int POST_N = SHOW_W - PRE_DEPTH;
    localparam int PRE_W  = $clog2(PRE_DEPTH + 1);
    localparam int POST_W = $clog2(POST_N + 1);

    cap_state_t          state_reg, state_next;
    logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [TB_MAX-1:0]   presc_reg, presc_next;
    logic [3:0]          tb_reg, tb_next;
    logic [PRE_W-1:0]    pre_cnt_reg, pre_cnt_next;
    logic [POST_W-1:0]   post_cnt_reg, post_cnt_next;
    logic [ADDR_W-1:0]   cap_start_reg, cap_start_next;
    logic [ADDR_W-1:0]   disp_start_reg, disp_start_next;
    logic                disp_bank_reg, disp_bank_next;
    logic                triggered_reg, triggered_next;
    logic [SAMPLE_W-1:0] prev_s_reg, prev_s_next;

    logic                capturing;
    logic                tick;
    logic                trig_hit;
    logic                force_trig;
    logic [TB_MAX-1:0]   tick_mask;
    logic [ADDR_W-1:0]   rd_offset;

    assign capturing = (state_reg == PRE_FILL) || (state_reg == ARMED) ||
                       (state_reg == POST_FILL);
    // tb of 10 shifts every bit out, giving the full 1023 mask.
    assign tick_mask = ~({TB_MAX{1'b1}} << tb_reg);
    assign tick      = capturing && adc_valid && (presc_reg == tick_mask);

    always_comb begin
        trig_hit = 1'b0;
        if (slope_t'(trig_slope) == SLOPE_RISE) begin
            trig_hit = (prev_s_reg < trig_level) && (adc_data >= trig_level);
        end else begin
            trig_hit = (prev_s_reg > trig_level) && (adc_data <= trig_level);
        end
    end

`ifdef AUTO_TRIG_EN
    localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [AUTO_W-1:0] auto_cnt_reg;

    // Held at zero outside ARMED, so every entry to ARMED starts a fresh timeout.
    always_ff @(posedge clk) begin
        if (rst || (state_reg != ARMED)) begin
            auto_cnt_reg <= '0;
        end else if (tick) begin
            auto_cnt_reg <= auto_cnt_reg + 1'b1;
        end
    end

    assign force_trig = (auto_cnt_reg == AUTO_W'(AUTO_TIMEOUT - 1));
`else
    assign force_trig = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        presc_next      = presc_reg;
        tb_next         = tb_reg;
        pre_cnt_next    = pre_cnt_reg;
        post_cnt_next   = post_cnt_reg;
        cap_start_next  = cap_start_reg;
        disp_start_next = disp_start_reg;
        disp_bank_next  = disp_bank_reg;
        triggered_next  = triggered_reg;
        prev_s_next     = prev_s_reg;

        if (capturing && adc_valid) begin
            presc_next = tick ? '0 : presc_reg + 1'b1;
        end
        if (tick) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
            prev_s_next = adc_data;
        end

        case (state_reg)
            IDLE: begin
                tb_next    = clamp_tb(timebase);
                presc_next = '0;
                if (run) begin
                    state_next   = PRE_FILL;
                    pre_cnt_next = '0;
                    wr_ptr_next  = '0;
                end
            end
            PRE_FILL: begin
                if (tick) begin
                    if (pre_cnt_reg == PRE_W'(PRE_DEPTH - 1)) begin
                        state_next = ARMED;
                    end else begin
                        pre_cnt_next = pre_cnt_reg + 1'b1;
                    end
                end
            end
            ARMED: begin
                // The trigger sample is post sample 0; window starts PRE_DEPTH earlier.
                if (tick && (trig_hit || force_trig)) begin
                    cap_start_next = wr_ptr_reg - ADDR_W'(PRE_DEPTH);
                    triggered_next = trig_hit;
                    post_cnt_next  = POST_W'(1);
                    state_next     = (POST_N == 1) ? DONE : POST_FILL;
                end
            end
            POST_FILL: begin
                if (tick) begin
                    if (post_cnt_reg == POST_W'(POST_N - 1)) begin
                        state_next = DONE;
                    end else begin
                        post_cnt_next = post_cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                tb_next    = clamp_tb(timebase);
                presc_next = '0;
                if (frame_done) begin
                    disp_bank_next  = ~disp_bank_reg;
                    disp_start_next = cap_start_reg;
                    triggered_next  = 1'b0;
                    pre_cnt_next    = '0;
                    wr_ptr_next     = '0;
                    state_next      = run ? PRE_FILL : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            presc_reg      <= '0;
            tb_reg         <= '0;
            pre_cnt_reg    <= '0;
            post_cnt_reg   <= '0;
            cap_start_reg  <= '0;
            disp_start_reg <= '0;
            disp_bank_reg  <= 1'b0;
            triggered_reg  <= 1'b0;
            prev_s_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            presc_reg      <= presc_next;
            tb_reg         <= tb_next;
            pre_cnt_reg    <= pre_cnt_next;
            post_cnt_reg   <= post_cnt_next;
            cap_start_reg  <= cap_start_next;
            disp_start_reg <= disp_start_next;
            disp_bank_reg  <= disp_bank_next;
            triggered_reg  <= triggered_next;
            prev_s_reg     <= prev_s_next;
        end
    end

    assign rd_offset = disp_start_reg + get_show_data_cnt;

    capture_ram #(
        .AW (ADDR_W + 1),
        .DW (SAMPLE_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (tick),
        .waddr ({~disp_bank_reg, wr_ptr_reg}),
        .wdata (adc_data),
        .raddr ({disp_bank_reg, rd_offset}),
        .rdata (get_show_data)
    );

    assign capture_busy = capturing;
    assign triggered    = triggered_reg;
    assign disp_bank    = disp_bank_reg;

endmodule
